// File: rtl/multi_countdown.sv
// -----------------------------------------------------------------------------
// multi_countdown
//
// Bank of NUM_CH independent countdown timers behind one start port and one
// abort port. A started channel is busy for exactly the requested number of
// cycles (clamped to MAX_AMOUNT), then raises a registered one-cycle done
// pulse. Periodic channels reload themselves and pulse done every period
// until they are aborted.
//
// Ports
//   CLK             clock
//   nRST            synchronous, active-low reset
//   start__ENA      start request
//   start_ch        channel to start
//   start_amount    requested count (clamped to MAX_AMOUNT, 0 = no-op)
//   start_periodic  1 = auto-reload mode
//   start__RDY      start accepted this cycle if start__ENA is high
//   abort__ENA      abort request (always ready)
//   abort_ch        channel to abort (out-of-range index ignored)
//   busy            per-channel counter != 0
//   busy__RDY       constant 1
//   done            per-channel registered expiry pulse
//   any_busy        OR of busy
// -----------------------------------------------------------------------------
module multi_countdown #(
    parameter int NUM_CH     = 4,
    parameter int WIDTH      = 16,
    parameter int MAX_AMOUNT = 22,
    parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              start__ENA,
    input  logic [CH_W-1:0]   start_ch,
    input  logic [WIDTH-1:0]  start_amount,
    input  logic              start_periodic,
    output logic              start__RDY,
    input  logic              abort__ENA,
    input  logic [CH_W-1:0]   abort_ch,
    output logic [NUM_CH-1:0] busy,
    output logic              busy__RDY,
    output logic [NUM_CH-1:0] done,
    output logic              any_busy
);

    localparam logic [WIDTH-1:0] MAX_AMT_W = WIDTH'(MAX_AMOUNT);
    localparam logic [WIDTH-1:0] ONE_W     = WIDTH'(1);

    logic [WIDTH-1:0]  r_cnt    [NUM_CH];
    logic [WIDTH-1:0]  r_reload [NUM_CH];
    logic [NUM_CH-1:0] r_periodic;
    logic [NUM_CH-1:0] r_done;

    logic [NUM_CH-1:0] w_start_hit;
    logic [NUM_CH-1:0] w_abort_hit;
    logic [NUM_CH-1:0] w_idle;
    logic [WIDTH-1:0]  w_amt;
    logic              w_accept;

    // Clamp compares the full request, so any oversize value saturates.
    assign w_amt = (start_amount > MAX_AMT_W) ? MAX_AMT_W : start_amount;

    // Channel decode is one-hot and empty for an out-of-range index, so an
    // out-of-range start never reports ready and an out-of-range abort hits
    // nothing. Masking with ~w_abort_hit makes abort win on the same channel.
    assign start__RDY = |(w_start_hit & w_idle & ~w_abort_hit);
    assign w_accept   = start__ENA && start__RDY;

    assign busy      = ~w_idle;
    assign busy__RDY = 1'b1;
    assign done      = r_done;
    assign any_busy  = |busy;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign w_start_hit[gi] = (start_ch == CH_W'(gi));
            assign w_abort_hit[gi] = abort__ENA && (abort_ch == CH_W'(gi));
            assign w_idle[gi]      = (r_cnt[gi] == '0);

            // A start can only land on an idle channel, so it never competes
            // with the count rule; only abort needs explicit priority.
            always_ff @(posedge CLK) begin
                if (!nRST) begin
                    r_cnt[gi]      <= '0;
                    r_reload[gi]   <= '0;
                    r_periodic[gi] <= 1'b0;
                    r_done[gi]     <= 1'b0;
                end else if (w_abort_hit[gi]) begin
                    r_cnt[gi]      <= '0;
                    r_periodic[gi] <= 1'b0;
                    r_done[gi]     <= 1'b0;
                end else if (w_accept && w_start_hit[gi] && (w_amt != '0)) begin
                    r_cnt[gi]      <= w_amt;
                    r_reload[gi]   <= w_amt;
                    r_periodic[gi] <= start_periodic;
                    r_done[gi]     <= 1'b0;
                end else if (r_cnt[gi] > ONE_W) begin
                    r_cnt[gi]  <= r_cnt[gi] - ONE_W;
                    r_done[gi] <= 1'b0;
                end else if (r_cnt[gi] == ONE_W) begin
                    r_cnt[gi]  <= r_periodic[gi] ? r_reload[gi] : '0;
                    r_done[gi] <= 1'b1;
                end else begin
                    r_done[gi] <= 1'b0;
                end
            end
        end
    endgenerate

`ifdef FORMAL
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_formal
            always @(posedge CLK) begin
                assert (r_cnt[gi] <= MAX_AMT_W);
                if (r_done[gi])
                    assert ($past(r_cnt[gi]) == ONE_W);
                if ($past(w_abort_hit[gi]))
                    assert (r_cnt[gi] == '0);
                if (busy[gi] && w_start_hit[gi])
                    assert (!start__RDY);
            end
        end
    endgenerate
`endif

endmodule

// File: tb/tb_multi_countdown.sv
// -----------------------------------------------------------------------------
// tb_multi_countdown
//
// Directed stimulus with hand-computed expectations. The stimulus process
// pushes per-cycle expectations into a scoreboard queue; a monitor on the
// falling edge pops entries for the current cycle and compares them.
// A second instance with NUM_CH=5 exercises out-of-range channel indices.
// -----------------------------------------------------------------------------
module tb_multi_countdown;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        nRST;

    // Main DUT: default parameters (NUM_CH=4, WIDTH=16, MAX_AMOUNT=22).
    logic        start__ENA;
    logic [1:0]  start_ch;
    logic [15:0] start_amount;
    logic        start_periodic;
    logic        start__RDY;
    logic        abort__ENA;
    logic [1:0]  abort_ch;
    logic [3:0]  busy;
    logic        busy__RDY;
    logic [3:0]  done;
    logic        any_busy;

    // Second DUT: NUM_CH=5 so indices 5..7 are representable but invalid.
    logic        s5_ena;
    logic [2:0]  s5_ch;
    logic [15:0] s5_amt;
    logic        s5_per;
    logic        s5_rdy;
    logic        s5_abort;
    logic [2:0]  s5_abort_ch;
    logic [4:0]  s5_busy;
    logic        s5_busy_rdy;
    logic [4:0]  s5_done;
    logic        s5_any;

    multi_countdown u_dut (
        .CLK           (CLK),
        .nRST          (nRST),
        .start__ENA    (start__ENA),
        .start_ch      (start_ch),
        .start_amount  (start_amount),
        .start_periodic(start_periodic),
        .start__RDY    (start__RDY),
        .abort__ENA    (abort__ENA),
        .abort_ch      (abort_ch),
        .busy          (busy),
        .busy__RDY     (busy__RDY),
        .done          (done),
        .any_busy      (any_busy)
    );

    multi_countdown #(.NUM_CH(5)) u_dut5 (
        .CLK           (CLK),
        .nRST          (nRST),
        .start__ENA    (s5_ena),
        .start_ch      (s5_ch),
        .start_amount  (s5_amt),
        .start_periodic(s5_per),
        .start__RDY    (s5_rdy),
        .abort__ENA    (s5_abort),
        .abort_ch      (s5_abort_ch),
        .busy          (s5_busy),
        .busy__RDY     (s5_busy_rdy),
        .done          (s5_done),
        .any_busy      (s5_any)
    );

    typedef struct packed {
        int         cyc;
        logic [4:0] busy;
        logic [4:0] done;
        bit         chk_bd;
        bit         chk_rdy;
        bit         rdy;
        bit         which;
    } exp_t;

    exp_t  sb_q[$];
    string tag_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc    = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    // ---------------- scoreboard helpers ----------------
    function automatic void push_bd(input int c, input logic [4:0] b,
                                    input logic [4:0] d, input bit which,
                                    input string tag);
        exp_t e;
        e.cyc = c; e.busy = b; e.done = d;
        e.chk_bd = 1'b1; e.chk_rdy = 1'b0; e.rdy = 1'b0; e.which = which;
        sb_q.push_back(e);
        tag_q.push_back(tag);
    endfunction

    function automatic void push_rdy(input int c, input bit r, input bit which,
                                     input string tag);
        exp_t e;
        e.cyc = c; e.busy = '0; e.done = '0;
        e.chk_bd = 1'b0; e.chk_rdy = 1'b1; e.rdy = r; e.which = which;
        sb_q.push_back(e);
        tag_q.push_back(tag);
    endfunction

    task automatic check_entry(input exp_t e, input string tag);
        logic [4:0] ab;
        logic [4:0] ad;
        logic       aany;
        logic       ardy;
        if (e.which) begin
            ab = s5_busy; ad = s5_done; aany = s5_any; ardy = s5_rdy;
        end else begin
            ab = {1'b0, busy}; ad = {1'b0, done}; aany = any_busy; ardy = start__RDY;
        end
        if (e.chk_bd) begin
            checks++;
            if (ab !== e.busy) begin
                errors++;
                $display("FAIL %s busy cyc=%0d got=%b exp=%b", tag, cyc, ab, e.busy);
            end
            checks++;
            if (ad !== e.done) begin
                errors++;
                $display("FAIL %s done cyc=%0d got=%b exp=%b", tag, cyc, ad, e.done);
            end
            checks++;
            if (aany !== (|e.busy)) begin
                errors++;
                $display("FAIL %s any_busy cyc=%0d got=%b exp=%b", tag, cyc, aany, |e.busy);
            end
        end
        if (e.chk_rdy) begin
            checks++;
            if (ardy !== e.rdy) begin
                errors++;
                $display("FAIL %s start__RDY cyc=%0d got=%b exp=%b", tag, cyc, ardy, e.rdy);
            end
        end
    endtask

    // Monitor: falling edge, away from the active edge and after stimulus.
    always @(negedge CLK) begin
        for (int i = sb_q.size() - 1; i >= 0; i--) begin
            if (sb_q[i].cyc == cyc) begin
                check_entry(sb_q[i], tag_q[i]);
                sb_q.delete(i);
                tag_q.delete(i);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic idle_all();
        start__ENA = 1'b0; start_ch = '0; start_amount = '0; start_periodic = 1'b0;
        abort__ENA = 1'b0; abort_ch = '0;
        s5_ena = 1'b0; s5_ch = '0; s5_amt = '0; s5_per = 1'b0;
        s5_abort = 1'b0; s5_abort_ch = '0;
    endtask

    task automatic drv_start(input bit which, input int ch, input int amt, input bit per);
        if (which) begin
            s5_ena = 1'b1; s5_ch = 3'(ch); s5_amt = 16'(amt); s5_per = per;
        end else begin
            start__ENA = 1'b1; start_ch = 2'(ch); start_amount = 16'(amt);
            start_periodic = per;
        end
        $display("cyc=%0d dut%0d start ch=%0d amt=%0d periodic=%0d", cyc, which, ch, amt, per);
    endtask

    task automatic drv_abort(input bit which, input int ch);
        if (which) begin
            s5_abort = 1'b1; s5_abort_ch = 3'(ch);
        end else begin
            abort__ENA = 1'b1; abort_ch = 2'(ch);
        end
        $display("cyc=%0d dut%0d abort ch=%0d", cyc, which, ch);
    endtask

    // ---------------- directed test ----------------
    initial begin
        int c;
        int t;
        logic [4:0] eb;
        logic [4:0] ed;

        nRST = 1'b0;
        idle_all();
        tick(3);

        // Reset state
        push_bd(cyc, 5'b0, 5'b0, 0, "reset");
        push_rdy(cyc, 1, 0, "reset_rdy");
        push_bd(cyc, 5'b0, 5'b0, 1, "reset5");
        tick();
        nRST = 1'b1;
        tick(2);

        // One-shot ch1, amount 5
        c = cyc; t = c + 1;
        drv_start(0, 1, 5, 0);
        push_rdy(c, 1, 0, "os_rdy");
        for (int k = 0; k < 5; k++) push_bd(t + k, 5'b00010, 5'b0, 0, "os_busy");
        push_bd(t + 5, 5'b0, 5'b00010, 0, "os_done");
        push_bd(t + 6, 5'b0, 5'b0, 0, "os_after");
        tick();
        idle_all();
        tick(7);

        // Clamp: ch0 amount 1000 -> 22 cycles; then amount 0 on ch3 is a no-op
        c = cyc; t = c + 1;
        drv_start(0, 0, 1000, 0);
        push_rdy(c, 1, 0, "clamp_rdy");
        push_rdy(c + 1, 1, 0, "amt0_rdy");
        for (int k = 0; k < 22; k++) push_bd(t + k, 5'b00001, 5'b0, 0, "clamp_busy");
        push_bd(t + 22, 5'b0, 5'b00001, 0, "clamp_done");
        push_bd(t + 23, 5'b0, 5'b0, 0, "clamp_after");
        push_bd(t + 24, 5'b0, 5'b0, 0, "clamp_after");
        tick();
        drv_start(0, 3, 0, 0);
        tick();
        idle_all();
        tick(24);

        // Periodic ch2, amount 3: done every 3 cycles, abort while cnt==1
        c = cyc; t = c + 1;
        drv_start(0, 2, 3, 1);
        push_rdy(c, 1, 0, "per_rdy");
        for (int k = 0; k < 15; k++)
            push_bd(t + k, 5'b00100,
                    (k == 3 || k == 6 || k == 9 || k == 12) ? 5'b00100 : 5'b0, 0, "per_run");
        for (int k = 15; k < 20; k++) push_bd(t + k, 5'b0, 5'b0, 0, "per_aborted");
        tick();
        idle_all();
        tick(5);
        drv_start(0, 2, 7, 0);
        push_rdy(t + 5, 0, 0, "per_busy_rdy");
        tick();
        idle_all();
        tick(8);
        drv_abort(0, 2);
        tick();
        idle_all();
        tick(5);

        // Busy ch3 rejects start; ch0 runs alongside; ch3 restarts on its done cycle
        c = cyc; t = c + 1;
        drv_start(0, 3, 6, 0);
        push_rdy(c, 1, 0, "ch3_rdy");
        for (int k = 0; k < 12; k++) begin
            eb = '0; ed = '0;
            eb[3] = (k <= 5) || (k == 7) || (k == 8);
            ed[3] = (k == 6) || (k == 9);
            eb[0] = (k >= 4) && (k <= 7);
            ed[0] = (k == 8);
            push_bd(t + k, eb, ed, 0, "dual_run");
        end
        tick();
        idle_all();
        tick(2);
        drv_start(0, 3, 2, 0);
        push_rdy(t + 2, 0, 0, "ch3_busy_rdy");
        tick();
        drv_start(0, 0, 4, 0);
        push_rdy(t + 3, 1, 0, "ch0_rdy");
        tick();
        idle_all();
        tick(2);
        drv_start(0, 3, 2, 0);
        push_rdy(t + 6, 1, 0, "restart_rdy");
        tick();
        idle_all();
        tick(5);

        // Start+abort same channel (abort wins), then different channels
        c = cyc;
        drv_start(0, 0, 10, 0);
        push_rdy(c, 1, 0, "sa_ch0_rdy");
        push_bd(c + 1, 5'b00001, 5'b0, 0, "sa_run");
        push_bd(c + 2, 5'b00001, 5'b0, 0, "sa_run");
        push_bd(c + 3, 5'b00010, 5'b0, 0, "sa_swap");
        push_bd(c + 4, 5'b00010, 5'b0, 0, "sa_swap");
        push_bd(c + 5, 5'b0, 5'b00010, 0, "sa_done");
        for (int k = 6; k < 9; k++) push_bd(c + k, 5'b0, 5'b0, 0, "sa_after");
        tick();
        drv_start(0, 1, 5, 0);
        drv_abort(0, 1);
        push_rdy(c + 1, 0, 0, "st_ab_same");
        tick();
        drv_start(0, 1, 2, 0);
        drv_abort(0, 0);
        push_rdy(c + 2, 1, 0, "st_ab_diff");
        tick();
        idle_all();
        tick(6);

        // Reset while ch0 is at cnt=10 and ch2 is periodic
        c = cyc;
        drv_start(0, 2, 3, 1);
        push_rdy(c, 1, 0, "rst_per_rdy");
        push_rdy(c + 1, 1, 0, "rst_ch0_rdy");
        push_bd(c + 1, 5'b00100, 5'b0, 0, "rst_pre");
        push_bd(c + 2, 5'b00101, 5'b0, 0, "rst_pre");
        push_bd(c + 3, 5'b00101, 5'b0, 0, "rst_pre");
        push_bd(c + 4, 5'b00101, 5'b00100, 0, "rst_pre");
        for (int k = 5; k < 17; k++) push_bd(c + k, 5'b0, 5'b0, 0, "rst_post");
        tick();
        drv_start(0, 0, 12, 0);
        tick();
        idle_all();
        tick(2);
        nRST = 1'b0;
        tick();
        nRST = 1'b1;
        tick(12);

        // Out-of-range channel indices on the NUM_CH=5 instance
        c = cyc;
        drv_start(1, 5, 3, 0);
        push_rdy(c, 0, 1, "oor5_rdy");
        push_rdy(c + 1, 0, 1, "oor7_rdy");
        push_rdy(c + 2, 1, 1, "ch4_rdy");
        push_rdy(c + 3, 0, 1, "ch4_busy_rdy");
        push_bd(c + 1, 5'b0, 5'b0, 1, "oor_idle");
        push_bd(c + 2, 5'b0, 5'b0, 1, "oor_idle");
        for (int k = 3; k < 6; k++) push_bd(c + k, 5'b10000, 5'b0, 1, "ch4_busy");
        push_bd(c + 6, 5'b0, 5'b10000, 1, "ch4_done");
        push_bd(c + 7, 5'b0, 5'b0, 1, "ch4_after");
        tick();
        drv_start(1, 7, 3, 0);
        tick();
        drv_start(1, 4, 3, 0);
        tick();
        drv_start(1, 4, 3, 0);
        drv_abort(1, 6);
        tick();
        idle_all();
        tick(4);

        tick(3);

        checks++;
        if (busy__RDY !== 1'b1 || s5_busy_rdy !== 1'b1) begin
            errors++;
            $display("FAIL busy__RDY got=%b/%b exp=1/1", busy__RDY, s5_busy_rdy);
        end

        // Any expectation never reached by the monitor counts as an error.
        for (int i = 0; i < sb_q.size(); i++) begin
            errors++;
            $display("FAIL %s unchecked cyc=%0d now=%0d", tag_q[i], sb_q[i].cyc, cyc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
